// File: rtl/spinner_round_ctrl_if.sv
// spinner_round_ctrl_if: pins between the round sequencer, the user buttons and led_spinner.
// master = sequencer side, slave = the surrounding game logic / spinner side.
interface spinner_round_ctrl_if;
    logic       btn_start_i;
    logic       btn_stop_i;
    logic [3:0] speed_base_i;
    logic       tick_i;
    logic       running_i;
    logic       hit_i;
    logic [3:0] speed_o;
    logic       stop_o;
    logic [3:0] score_o;
    logic [2:0] lives_o;
    logic       game_over_o;
    logic [2:0] state_o;

    modport master (
        input  btn_start_i, btn_stop_i, speed_base_i,
        input  tick_i, running_i, hit_i,
        output speed_o, stop_o, score_o, lives_o,
        output game_over_o, state_o
    );

    modport slave (
        output btn_start_i, btn_stop_i, speed_base_i,
        output tick_i, running_i, hit_i,
        input  speed_o, stop_o, score_o, lives_o,
        input  game_over_o, state_o
    );
endinterface

// File: rtl/spinner_round_ctrl.sv
// spinner_round_ctrl: debounced round sequencer with braking, scoring and lives.
// Define SPINNER_CTRL_AUTOSTOP_EN to brake automatically after AUTOSTOP_TICKS in SPIN.
module spinner_round_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BRAKE_STEP      = 8,
    parameter int SETTLE_MAX      = 4095,
    parameter int LIVES           = 3
`ifdef SPINNER_CTRL_AUTOSTOP_EN
    ,
    parameter int AUTOSTOP_TICKS  = 200
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spinner_round_ctrl_if.master bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam int BW = (BRAKE_STEP > 1) ? $clog2(BRAKE_STEP) : 1;
    localparam logic [BW-1:0] BRK_LAST = BW'(BRAKE_STEP - 1);
    localparam int SW = $clog2(SETTLE_MAX + 1);
    localparam logic [SW-1:0] STL_MAX = SW'(SETTLE_MAX);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
`ifdef SPINNER_CTRL_AUTOSTOP_EN
    localparam int AW = (AUTOSTOP_TICKS > 1) ? $clog2(AUTOSTOP_TICKS) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOSTOP_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPIN   = 3'd1,
        S_BRAKE  = 3'd2,
        S_SETTLE = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    logic [1:0]    rst_pipe;
    logic          rst_sync_n;
    logic [1:0]    btn_raw;
    logic [1:0]    sync0;
    logic [1:0]    sync1;
    logic [1:0]    lvl;
    logic [1:0]    lvl_q;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    press;
    logic          start_p;
    logic          stop_p;

    state_t        state;
    state_t        state_n;
    logic [3:0]    speed;
    logic [3:0]    speed_n;
    logic          stop;
    logic          stop_n;
    logic [3:0]    score;
    logic [3:0]    score_n;
    logic [2:0]    lives;
    logic [2:0]    lives_n;
    logic          over;
    logic [BW-1:0] brk;
    logic [BW-1:0] brk_n;
    logic [SW-1:0] stl;
    logic [SW-1:0] stl_n;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
    logic [AW-1:0] auto_cnt;
    logic [AW-1:0] auto_n;
`endif

    assign rst_sync_n = rst_pipe[1];
    assign btn_raw    = {bus.btn_stop_i, bus.btn_start_i};
    assign press      = lvl & ~lvl_q;
    assign start_p    = press[0];
    assign stop_p     = press[1];

    // Reset asserts immediately, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end

    // Two-flop synchroniser plus stable-level counter per button.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sync0 <= '0;
            sync1 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
            lvl_q <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync1[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= sync1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Round state register.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= S_IDLE;
        else             state <= state_n;
    end

    // Next state and next register values; presses outside their state are dropped.
    always_comb begin
        state_n = state;
        speed_n = speed;
        stop_n  = stop;
        score_n = score;
        lives_n = lives;
        brk_n   = brk;
        stl_n   = stl;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
        auto_n  = auto_cnt;
`endif
        case (state)
            S_IDLE: begin
                stop_n = 1'b1;
                if (start_p) begin
                    speed_n = bus.speed_base_i;
                    stop_n  = 1'b0;
                    state_n = S_SPIN;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
                    auto_n  = '0;
`endif
                end
            end
            S_SPIN: begin
`ifdef SPINNER_CTRL_AUTOSTOP_EN
                if (bus.tick_i) auto_n = auto_cnt + 1'b1;
                if (stop_p || (bus.tick_i && auto_cnt == AUTO_LAST)) begin
                    state_n = S_BRAKE;
                    brk_n   = '0;
                end
`else
                if (stop_p) begin
                    state_n = S_BRAKE;
                    brk_n   = '0;
                end
`endif
            end
            S_BRAKE: begin
                if (bus.tick_i) begin
                    if (brk == BRK_LAST) begin
                        brk_n = '0;
                        if (speed == 4'hF) begin
                            stop_n  = 1'b1;
                            state_n = S_SETTLE;
                            stl_n   = '0;
                        end else begin
                            speed_n = speed + 1'b1;
                        end
                    end else begin
                        brk_n = brk + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                stl_n = stl + 1'b1;
                if (!bus.running_i || stl_n == STL_MAX) state_n = S_RESULT;
            end
            S_RESULT: begin
                if (bus.hit_i) begin
                    if (score != 4'hF) score_n = score + 1'b1;
                    state_n = S_IDLE;
                end else begin
                    lives_n = lives - 1'b1;
                    state_n = (lives == 3'd1) ? S_OVER : S_IDLE;
                end
            end
            S_OVER: begin
                stop_n = 1'b1;
                if (start_p) begin
                    score_n = '0;
                    lives_n = LIVES_INIT;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered outputs and round counters.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            speed    <= '0;
            stop     <= 1'b1;
            score    <= '0;
            lives    <= LIVES_INIT;
            over     <= 1'b0;
            brk      <= '0;
            stl      <= '0;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
            auto_cnt <= '0;
`endif
        end else begin
            speed    <= speed_n;
            stop     <= stop_n;
            score    <= score_n;
            lives    <= lives_n;
            over     <= (state_n == S_OVER);
            brk      <= brk_n;
            stl      <= stl_n;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
            auto_cnt <= auto_n;
`endif
        end
    end

    assign bus.speed_o     = speed;
    assign bus.stop_o      = stop;
    assign bus.score_o     = score;
    assign bus.lives_o     = lives;
    assign bus.game_over_o = over;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_spinner_round_ctrl.sv
// tb_spinner_round_ctrl: randomized rounds scored against an event-level game model.
// Output changes are popped from an expected-event queue by an independent monitor.
module tb_spinner_round_ctrl;
    localparam int DB = 4;
    localparam int BS = 2;
    localparam int SM = 16;
    localparam int LV = 2;
    localparam int AS = 10;
    localparam int IDLE = 0, SPIN = 1, BRAKE = 2, SETTLE = 3, RESULT = 4, OVER = 5;

    typedef struct {
        logic [15:0] v;
        int          at;
        int          gap;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   m_score = 0;
    int   m_lives = LV;
    ev_t  q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spinner_round_ctrl_if bus();

    spinner_round_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BRAKE_STEP(BS),
        .SETTLE_MAX(SM),
        .LIVES(LV)
`ifdef SPINNER_CTRL_AUTOSTOP_EN
        ,
        .AUTOSTOP_TICKS(AS)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [15:0] pack(int st, int spd, int stp, int sc, int lv, int go);
        return {3'(st), 4'(spd), 1'(stp), 4'(sc), 3'(lv), 1'(go)};
    endfunction

    function automatic logic [15:0] snap();
        return {bus.state_o, bus.speed_o, bus.stop_o,
                bus.score_o, bus.lives_o, bus.game_over_o};
    endfunction

    task automatic push(int st, int spd, int stp, int sc, int lv, int go, int at, int gap);
        ev_t e;
        e.v   = pack(st, spd, stp, sc, lv, go);
        e.at  = at;
        e.gap = gap;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output bundle is one event.
    logic [15:0] prev = {3'd0, 4'd0, 1'b1, 4'd0, 3'(LV), 1'b0};
    int last_ev = 0;
    always @(negedge clk) begin
        logic [15:0] cur;
        ev_t e;
        cur = snap();
        if (cur != prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got=%h", cyc, cur);
            end else begin
                e = q.pop_front();
                if (cur != e.v || (e.at >= 0 && cyc != e.at) ||
                    (e.gap > 0 && cyc - last_ev != e.gap)) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h want=%h at=%0d gap=%0d/%0d",
                             cyc, cur, e.v, e.at, cyc - last_ev, e.gap);
                end
            end
            prev = cur;
            last_ev = cyc;
        end
    end

    // Wheel prescaler: one tick every 4 clocks.
    initial begin
        bus.tick_i = 1'b0;
        forever begin
            step(3);
            bus.tick_i = 1'b1;
            step(1);
            bus.tick_i = 1'b0;
        end
    end

    task automatic wait_st(int s, int lim, string tag);
        int n;
        n = 0;
        while (int'(bus.state_o) != s && n < lim) begin
            step(1);
            n++;
        end
        if (int'(bus.state_o) != s) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=%0d want=%0d", tag, bus.state_o, s);
        end
    endtask

    task automatic push_brake(int b, int at);
        push(BRAKE, b, 0, m_score, m_lives, 0, at, 0);
        for (int s = b + 1; s <= 15; s++) push(BRAKE, s, 0, m_score, m_lives, 0, -1, 0);
        push(SETTLE, 15, 1, m_score, m_lives, 0, -1, 0);
    endtask

    task automatic push_result(int at, int gap, bit hit);
        push(RESULT, 15, 1, m_score, m_lives, 0, at, gap);
        if (hit) begin
            m_score = (m_score == 15) ? 15 : m_score + 1;
            push(IDLE, 15, 1, m_score, m_lives, 0, -1, 1);
        end else begin
            m_lives--;
            push(m_lives == 0 ? OVER : IDLE, 15, 1, m_score, m_lives,
                 m_lives == 0 ? 1 : 0, -1, 1);
        end
    endtask

    task automatic restart();
        int k;
        step(1);
        k = cyc;
        m_score = 0;
        m_lives = LV;
        push(IDLE, 15, 1, 0, LV, 0, k + DB + 3, 0);
        bus.btn_start_i = 1'b1;
        step(10);
        bus.btn_start_i = 1'b0;
        step(10);
    endtask

    task automatic round(int b, bit use_stop, bit both, bit hold, bit hit, bit extra);
        int k;
        int d;
        bit do_stop;
        if (m_lives == 0) restart();
        bus.running_i = 1'b1;
        bus.hit_i = hit;
        bus.speed_base_i = 4'(b);
        step(1);
        k = cyc;
        push(SPIN, b, 0, m_score, m_lives, 0, k + DB + 3, 0);
        do_stop = use_stop;
`ifdef SPINNER_CTRL_AUTOSTOP_EN
        if (!use_stop) push_brake(b, -1);
`endif
        bus.btn_start_i = 1'b1;
        bus.btn_stop_i = both;
        step(10);
        bus.btn_start_i = 1'b0;
        bus.btn_stop_i = 1'b0;
        step(8);
`ifndef SPINNER_CTRL_AUTOSTOP_EN
        if (!use_stop) begin
            step(400);
            checks++;
            if (int'(bus.state_o) != SPIN) begin
                errors++;
                $display("FAIL spin_hold got=%0d want=%0d", bus.state_o, SPIN);
            end
            do_stop = 1'b1;
        end
`endif
        if (do_stop) begin
            step($urandom_range(0, 3));
            k = cyc;
            push_brake(b, k + DB + 3);
            bus.btn_stop_i = 1'b1;
            step(10);
            bus.btn_stop_i = 1'b0;
            if (extra) begin
                step(8);
                bus.btn_stop_i = 1'b1;
                bus.btn_start_i = 1'b1;
                step(10);
                bus.btn_stop_i = 1'b0;
                bus.btn_start_i = 1'b0;
            end
        end
        wait_st(SETTLE, 600, "settle");
        if (hold) begin
            push_result(-1, SM, hit);
        end else begin
            d = $urandom_range(0, 10);
            step(d);
            k = cyc;
            push_result(k + 1, 0, hit);
            bus.running_i = 1'b0;
        end
        step(SM + 4);
    endtask

    initial begin
        logic [15:0] rv;
        int b;
        bus.btn_start_i = 1'b0;
        bus.btn_stop_i = 1'b0;
        bus.speed_base_i = 4'd0;
        bus.running_i = 1'b0;
        bus.hit_i = 1'b0;
        step(3);
        rv = pack(IDLE, 0, 1, 0, LV, 0);
        checks++;
        if (snap() != rv) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", snap(), rv);
        end
        rst_n = 1'b1;
        step(4);

        step(1);
        bus.btn_start_i = 1'b1;
        step(2);
        bus.btn_start_i = 1'b0;
        step(12);
        round(12, 1, 0, 0, 1, 0);

        round(7, 1, 0, 0, 0, 0);
        round(9, 1, 0, 0, 0, 0);
        restart();

        round(4, 1, 0, 1, 1'($urandom_range(0, 1)), 0);
        round(3, 1, 1, 0, 1, 1);
        round(10, 0, 0, 0, 1, 0);

        for (int i = 0; i < 16; i++) round(15, 1, 0, 0, 1, 0);

        for (int i = 0; i < 12; i++) begin
            b = $urandom_range(0, 15);
            round(b, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  (b <= 10) && ($urandom_range(0, 1) == 1));
        end

        if (m_lives == 0) restart();
        bus.speed_base_i = 4'd5;
        bus.running_i = 1'b1;
        step(1);
        push(SPIN, 5, 0, m_score, m_lives, 0, cyc + DB + 3, 0);
        bus.btn_start_i = 1'b1;
        step(10);
        bus.btn_start_i = 1'b0;
        step(2);
        push(IDLE, 0, 1, 0, LV, 0, -1, 0);
        m_score = 0;
        m_lives = LV;
        rst_n = 1'b0;
        #1;
        checks++;
        if (snap() != pack(IDLE, 0, 1, 0, LV, 0)) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", snap(), pack(IDLE, 0, 1, 0, LV, 0));
        end
        step(3);
        rst_n = 1'b1;
        step(6);

        for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
